// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the 5-stage MIPS pipeline. Each cycle it produces the
// stall/clear strobes for the PC, the IF/ID register and the ID/EX register.
// It handles three kinds of hazard:
//   - load-use data hazards;
//   - taken-branch flushes;
//   - structural hazards on the multi-cycle mult/div unit, which it tracks
//     with a small IDLE/BUSY FSM and a down-counter.
//
// Ports
//   clk              clock, all state changes on the rising edge
//   rst              synchronous active-high reset (also forces outputs to 0)
//   id_rs/id_rt      source register fields of the instruction in ID
//   id_use_rs/rt     ID instruction actually reads rs / rt
//   id_is_md         ID instruction is mult/multu/div/divu
//   id_reads_hilo    ID instruction is mfhi/mflo/mthi/mtlo
//   ex_memread       EX instruction is a load
//   ex_rt            destination register of that load
//   ex_branch_taken  branch/jump resolved taken in EX this cycle
//   pc_stall         hold PC
//   ifid_stall       hold IF/ID
//   ifid_clr         clear IF/ID to a nop
//   idex_clr         clear ID/EX (insert bubble)
//   md_start         mult/div issues into EX this cycle
//   md_busy          mult/div unit occupied
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int MD_LAT = 32,
    parameter int CNT_W  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       id_use_rs,
    input  logic       id_use_rt,
    input  logic       id_is_md,
    input  logic       id_reads_hilo,
    input  logic       ex_memread,
    input  logic [4:0] ex_rt,
    input  logic       ex_branch_taken,
    output logic       pc_stall,
    output logic       ifid_stall,
    output logic       ifid_clr,
    output logic       idex_clr,
    output logic       md_start,
    output logic       md_busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // The busy phase lasts MD_LAT cycles: MD_LAT-1 down to 0 inclusive.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic flush;
    logic load_use;
    logic struct_haz;
    logic busy;
    logic start;

    always_comb begin
        flush      = ex_branch_taken;
        load_use   = ex_memread && (ex_rt != 5'd0) &&
                     ((id_use_rs && (id_rs == ex_rt)) ||
                      (id_use_rt && (id_rt == ex_rt)));
        busy       = (state_q == BUSY);
        struct_haz = busy && (id_is_md || id_reads_hilo);
        // A mult/div issues only if it is not being flushed and is not
        // itself waiting on a load; in BUSY the structural stall holds it.
        start      = !busy && id_is_md && !flush && !load_use;

        pc_stall   = 1'b0;
        ifid_stall = 1'b0;
        ifid_clr   = 1'b0;
        idex_clr   = 1'b0;
        md_start   = 1'b0;
        md_busy    = 1'b0;

        if (!rst) begin
            if (flush) begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (load_use || struct_haz) begin
                pc_stall   = 1'b1;
                ifid_stall = 1'b1;
                idex_clr   = 1'b1;
            end
            md_start = start;
            md_busy  = busy;
        end
    end

    // Next-state logic. A flush never aborts the counter: the mult/div
    // already in flight still commits its result.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = CNT_INIT;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Bench for hazard_ctrl with MD_LAT = 4. Outputs are packed as
// {pc_stall, ifid_stall, ifid_clr, idex_clr, md_start, md_busy}.
// A reference model derives the busy window from the cycle index of the last
// mult/div issue and checks every cycle on the falling edge. Directed steps
// additionally post a literal expectation that is checked on the same edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int MD_LAT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic       id_use_rs, id_use_rt, id_is_md, id_reads_hilo;
    logic       ex_memread, ex_branch_taken;
    logic       pc_stall, ifid_stall, ifid_clr, idex_clr, md_start, md_busy;

    hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(6)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_is_md        (id_is_md),
        .id_reads_hilo   (id_reads_hilo),
        .ex_memread      (ex_memread),
        .ex_rt           (ex_rt),
        .ex_branch_taken (ex_branch_taken),
        .pc_stall        (pc_stall),
        .ifid_stall      (ifid_stall),
        .ifid_clr        (ifid_clr),
        .idex_clr        (idex_clr),
        .md_start        (md_start),
        .md_busy         (md_busy)
    );

    always #5 clk = ~clk;

    logic [5:0] outs;
    assign outs = {pc_stall, ifid_stall, ifid_clr, idex_clr, md_start, md_busy};

    int n_cmp = 0;
    int n_bad = 0;

    // Literal expectation posted by the directed stimulus.
    logic       lit_valid = 1'b0;
    logic [5:0] lit_exp   = 6'b0;
    string      lit_name  = "";

    // Model state: cycle index and the cycle in which the last issue happened.
    int cyc        = 0;
    bit have_issue = 1'b0;
    int last_issue = 0;

    function automatic logic [5:0] model_outs(int c);
        bit b, fl, lu, sh, st;
        b  = have_issue && (c > last_issue) && (c <= last_issue + MD_LAT);
        fl = ex_branch_taken;
        lu = ex_memread && (ex_rt != 0) &&
             ((id_use_rs && id_rs == ex_rt) || (id_use_rt && id_rt == ex_rt));
        sh = b && (id_is_md || id_reads_hilo);
        st = !b && id_is_md && !fl && !lu;
        if (rst) return 6'b0;
        if (fl)            return {1'b0, 1'b0, 1'b1, 1'b1, st, b};
        else if (lu || sh) return {1'b1, 1'b1, 1'b0, 1'b1, st, b};
        else               return {1'b0, 1'b0, 1'b0, 1'b0, st, b};
    endfunction

    always @(negedge clk) begin
        logic [5:0] exp_v;
        cyc++;
        exp_v = model_outs(cyc);
        n_cmp++;
        if (outs !== exp_v) begin
            n_bad++;
            $display("FAIL model cyc=%0d: got %b want %b", cyc, outs, exp_v);
        end
        if (lit_valid) begin
            n_cmp++;
            if (outs !== lit_exp) begin
                n_bad++;
                $display("FAIL %s: got %b want %b", lit_name, outs, lit_exp);
            end else begin
                $display("ok   %s: %b", lit_name, outs);
            end
        end
        if (rst) have_issue = 1'b0;
        else if (exp_v[1]) begin
            have_issue = 1'b1;
            last_issue = cyc;
        end
    end

    task automatic clr_in();
        id_rs = 0; id_rt = 0; ex_rt = 0;
        id_use_rs = 0; id_use_rt = 0; id_is_md = 0; id_reads_hilo = 0;
        ex_memread = 0; ex_branch_taken = 0;
    endtask

    // Advance to just after the next rising edge; drop any old literal.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        lit_valid = 1'b0;
    endtask

    task automatic expect_lit(string name, logic [5:0] v);
        lit_name  = name;
        lit_exp   = v;
        lit_valid = 1'b1;
    endtask

    initial begin
        rst = 1'b1;
        clr_in();
        next_cycle(); expect_lit("reset_outs_zero", 6'b000000);
        next_cycle(); rst = 1'b0; expect_lit("after_reset_idle", 6'b000000);

        // Load-use stall for one cycle, then released.
        next_cycle(); ex_memread = 1; ex_rt = 8; id_use_rs = 1; id_rs = 8;
        expect_lit("load_use_stall", 6'b110100);
        next_cycle(); ex_memread = 0;
        expect_lit("load_use_release", 6'b000000);

        // $zero never creates a load-use hazard.
        next_cycle(); ex_memread = 1; ex_rt = 0; id_rs = 0;
        expect_lit("zero_reg_exempt", 6'b000000);

        // Branch flush beats load-use.
        next_cycle(); ex_rt = 8; id_rs = 8; ex_branch_taken = 1;
        expect_lit("flush_over_lu", 6'b001100);

        // Mult/div issue followed by HI/LO access.
        next_cycle(); clr_in(); id_is_md = 1;
        expect_lit("md_issue", 6'b000010);
        for (int i = 1; i <= MD_LAT; i++) begin
            next_cycle(); id_is_md = 0; id_reads_hilo = 1;
            expect_lit($sformatf("hilo_stall_%0d", i), 6'b110101);
        end
        next_cycle(); expect_lit("hilo_release", 6'b000000);

        // Back-to-back mult/div.
        next_cycle(); clr_in(); id_is_md = 1;
        expect_lit("b2b_first", 6'b000010);
        for (int i = 1; i <= MD_LAT; i++) begin
            next_cycle(); expect_lit($sformatf("b2b_stall_%0d", i), 6'b110101);
        end
        next_cycle(); expect_lit("b2b_second", 6'b000010);
        next_cycle(); id_is_md = 0;
        for (int i = 0; i < MD_LAT; i++) next_cycle();

        // Reset during the second busy cycle.
        next_cycle(); id_is_md = 1; expect_lit("rst_md_issue", 6'b000010);
        next_cycle(); id_is_md = 0; expect_lit("rst_busy1", 6'b000001);
        next_cycle(); rst = 1; id_is_md = 1; expect_lit("rst_forced_zero", 6'b000000);
        next_cycle(); rst = 0; expect_lit("rst_reissue", 6'b000010);
        next_cycle(); clr_in();
        expect_lit("rst_reissue_busy", 6'b000001);

        // Randomized traffic, model-checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            rst             = ($urandom_range(0, 99) == 0);
            id_rs           = 5'($urandom_range(0, 3));
            id_rt           = 5'($urandom_range(0, 3));
            ex_rt           = 5'($urandom_range(0, 3));
            id_use_rs       = 1'($urandom);
            id_use_rt       = 1'($urandom);
            id_is_md        = ($urandom_range(0, 3) == 0);
            id_reads_hilo   = ($urandom_range(0, 3) == 0);
            ex_memread      = ($urandom_range(0, 2) == 0);
            ex_branch_taken = ($urandom_range(0, 7) == 0);
        end
        next_cycle(); rst = 0; clr_in();
        next_cycle();
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the 5-stage MIPS core. Every cycle it generates the stall and clear strobes for the PC, the IF/ID instruction register (its `stall`/`clr` inputs) and the ID/EX register. It covers three cases:
- load-use data hazards;
- taken-branch flushes;
- structural hazards on the multi-cycle mult/div unit, which it sequences with an internal busy counter.

## Interface
Parameters:
- MD_LAT, 32, cycles the mult/div unit stays busy after issue (legal range 1..63)
- CNT_W, 6, counter width; must satisfy 2^CNT_W > MD_LAT-1

Ports:
- clk  in  1  single clock; all state updates on posedge clk
- rst  in  1  synchronous, active-high reset
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_use_rs  in  1  ID instruction reads rs
- id_use_rt  in  1  ID instruction reads rt
- id_is_md  in  1  ID instruction is mult/multu/div/divu
- id_reads_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo
- ex_memread  in  1  EX instruction is a load
- ex_rt  in  5  destination register of the EX load
- ex_branch_taken  in  1  branch/jump resolved taken in EX this cycle
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID register
- ifid_clr  out  1  clear IF/ID register to 0 (nop)
- idex_clr  out  1  clear ID/EX register (insert bubble)
- md_start  out  1  one-cycle strobe: mult/div issues into EX this cycle
- md_busy  out  1  mult/div unit occupied

## Operation
- Internal state: FSM {IDLE, BUSY} and a down-counter cnt[CNT_W-1:0].
- Hazard terms (combinational):
  - FLUSH = ex_branch_taken.
  - LU = ex_memread & (ex_rt != 0) & ((id_use_rs & id_rs == ex_rt) | (id_use_rt & id_rt == ex_rt)).
  - SH = (state == BUSY) & (id_is_md | id_reads_hilo).
- Priority is FLUSH > LU > SH.
  - FLUSH: ifid_clr=1, idex_clr=1, pc_stall=0, ifid_stall=0.
  - LU (no FLUSH): pc_stall=1, ifid_stall=1, idex_clr=1, ifid_clr=0.
  - SH (no FLUSH, no LU): same outputs as LU.
  - None: all four strobes 0.
- md_start = (state == IDLE) & id_is_md & !FLUSH & !LU. It is never asserted in BUSY, because SH holds the instruction in ID.
- FSM transitions:
  - IDLE -> BUSY on md_start; cnt <= MD_LAT-1.
  - BUSY: if cnt == 0, go to IDLE; else cnt <= cnt-1.
- md_busy = (state == BUSY).
- FLUSH during BUSY does not abort the counter, because the mult/div already in flight commits.
- FLUSH while ID holds a mult/div: md_start=0, and that instruction is discarded.

## Timing
- All strobes are combinational from the current state and inputs; they act at the same posedge that the pipeline registers sample.
- Load-use costs exactly 1 bubble. On the next cycle the load is in MEM, so LU drops with no state needed.
- md_busy is high for exactly MD_LAT consecutive cycles, starting the cycle after md_start.
  - A following mult/div or HI/LO access in ID stalls during all of them.
  - It proceeds in the first IDLE cycle.
- Back-to-back mult/div: the second one issues (md_start) in the cycle md_busy first reads 0, i.e. MD_LAT+1 cycles after the first.
- Reset, including mid-BUSY: at the first posedge with rst=1, state <= IDLE and cnt <= 0. While rst=1, all outputs are forced to 0.
- After reset: md_busy=0, md_start=0, and all strobes 0 until the inputs create a hazard.

## Test plan
- Load-use stall:
  - Stimulus: ex_memread=1, ex_rt=8, id_use_rs=1, id_rs=8.
  - Required: pc_stall=ifid_stall=idex_clr=1 for 1 cycle, ifid_clr=0.
  - Then drop ex_memread: all strobes 0.
- $zero exemption: same stimulus as the load-use case but ex_rt=0, id_rs=0 -> no stall, all strobes 0.
- Flush overrides load-use:
  - Stimulus: ex_branch_taken=1 together with the load-use condition.
  - Required: ifid_clr=idex_clr=1, pc_stall=ifid_stall=0.
- Mult/div sequencing (MD_LAT=4):
  - Step 1: id_is_md=1 in IDLE -> md_start=1 for 1 cycle.
  - Step 2: then present id_reads_hilo=1 -> md_busy=1 and pc_stall=1 for exactly 4 cycles.
  - Step 3: in the 5th cycle md_busy=0 and the stall releases.
- Back-to-back mult/div (MD_LAT=4): hold id_is_md=1 throughout -> md_start at cycle 0 and again at cycle 5, with stalls in cycles 1-4.
- Reset mid-BUSY:
  - Stimulus: assert rst for 1 cycle at the 2nd busy cycle (MD_LAT=32).
  - Required: all outputs are 0 while rst=1; md_busy=0 on the next cycle; id_is_md=1 then issues immediately.
